comp_serial_nbits: RTL and testbench

Sequential, parametrised magnitude comparator for two WIDTH-bit operands. It scans the operands MSB-first, DIGIT bits per clock, and reports equal, greater or less through a start/busy/done handshake. It is the multi-cycle, width-generic successor to the team's combinational 4-bit comparator. It is intended for datapaths where a wide combinational compare chain would limit clock frequency.

---
 rtl/comp_serial_nbits.sv | 131 +++++++++++++
 tb/tb_comp_serial_nbits.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comp_serial_nbits.sv
// comp_serial_nbits: multi-cycle MSB-first magnitude comparator.
// Scans two WIDTH-bit operands DIGIT bits per clock and reports
// igual/maior/menor through a start/busy/done handshake.
// Optional feature macro: COMP_SIGNED_EN (adds the sinal port for a
// two's-complement compare).
module comp_serial_nbits #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 1,
  parameter int unsigned EARLY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
`ifdef COMP_SIGNED_EN
  input  logic             sinal,
`endif
  output logic             busy,
  output logic             done,
  output logic             igual,
  output logic             maior,
  output logic             menor
);

  localparam int unsigned N        = WIDTH / DIGIT;
  localparam int unsigned KW       = (N > 1) ? $clog2(N) : 1;
  localparam bit          EARLY_EN = (EARLY != 0);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             dec_q;
  logic             gt_q;

  logic             inv_msb;
  logic [WIDTH-1:0] flip;
  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic             diff;
  logic             dgt;
  logic             last;

  // Signed mode: inverting the sign bit maps two's complement onto unsigned order
  always_comb begin
`ifdef COMP_SIGNED_EN
    inv_msb = sinal;
`else
    inv_msb = 1'b0;
`endif
    flip            = '0;
    flip[WIDTH-1]   = inv_msb;
  end

  // Current digit of each shifted operand and its comparison
  always_comb begin
    dig_a = a_q[WIDTH-1 -: DIGIT];
    dig_b = b_q[WIDTH-1 -: DIGIT];
    diff  = (dig_a != dig_b);
    dgt   = (dig_a > dig_b);
    last  = (k_q == KW'(N - 1));
  end

  // Control FSM, operand shift registers and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dec_q   <= 1'b0;
      gt_q    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      igual   <= 1'b0;
      maior   <= 1'b0;
      menor   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= X ^ flip;
            b_q     <= Y ^ flip;
            k_q     <= '0;
            dec_q   <= 1'b0;
            gt_q    <= 1'b0;
            igual   <= 1'b0;
            maior   <= 1'b0;
            menor   <= 1'b0;
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if ((diff && EARLY_EN) || last) begin
            // A decision already latched (constant-time mode) wins over later digits
            if (dec_q) begin
              maior <= gt_q;
              menor <= ~gt_q;
            end else if (diff) begin
              maior <= dgt;
              menor <= ~dgt;
            end else begin
              igual <= 1'b1;
            end
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= IDLE;
          end else begin
            if (diff && !dec_q) begin
              dec_q <= 1'b1;
              gt_q  <= dgt;
            end
            k_q <= k_q + KW'(1);
            a_q <= a_q << DIGIT;
            b_q <= b_q << DIGIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comp_serial_nbits.sv
// Self-checking bench for comp_serial_nbits: several parameterisations,
// table-driven vectors with a result/latency scoreboard, plus hand-written
// multi-cycle sequences.
module tb_comp_serial_nbits;

  localparam logic [2:0] EQ = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // u_a: WIDTH=4 DIGIT=1 EARLY=1
  logic       start_a = 1'b0, sgn_a = 1'b0;
  logic [3:0] x_a = '0, y_a = '0;
  logic       busy_a, done_a, eq_a, gt_a, lt_a;
  // u_b: WIDTH=16 DIGIT=4 EARLY=1
  logic        start_b = 1'b0, sgn_b = 1'b0;
  logic [15:0] x_b = '0, y_b = '0;
  logic        busy_b, done_b, eq_b, gt_b, lt_b;
  // u_c: WIDTH=8 DIGIT=1 EARLY=0
  logic       start_c = 1'b0, sgn_c = 1'b0;
  logic [7:0] x_c = '0, y_c = '0;
  logic       busy_c, done_c, eq_c, gt_c, lt_c;
  // u_d: WIDTH=16 DIGIT=1 EARLY=1
  logic        start_d = 1'b0, sgn_d = 1'b0;
  logic [15:0] x_d = '0, y_d = '0;
  logic        busy_d, done_d, eq_d, gt_d, lt_d;

  comp_serial_nbits #(.WIDTH(4), .DIGIT(1), .EARLY(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .X(x_a), .Y(y_a),
`ifdef COMP_SIGNED_EN
    .sinal(sgn_a),
`endif
    .busy(busy_a), .done(done_a), .igual(eq_a), .maior(gt_a), .menor(lt_a));

  comp_serial_nbits #(.WIDTH(16), .DIGIT(4), .EARLY(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .X(x_b), .Y(y_b),
`ifdef COMP_SIGNED_EN
    .sinal(sgn_b),
`endif
    .busy(busy_b), .done(done_b), .igual(eq_b), .maior(gt_b), .menor(lt_b));

  comp_serial_nbits #(.WIDTH(8), .DIGIT(1), .EARLY(0)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .X(x_c), .Y(y_c),
`ifdef COMP_SIGNED_EN
    .sinal(sgn_c),
`endif
    .busy(busy_c), .done(done_c), .igual(eq_c), .maior(gt_c), .menor(lt_c));

  comp_serial_nbits #(.WIDTH(16), .DIGIT(1), .EARLY(1)) u_d (
    .clk(clk), .rst(rst), .start(start_d), .X(x_d), .Y(y_d),
`ifdef COMP_SIGNED_EN
    .sinal(sgn_d),
`endif
    .busy(busy_d), .done(done_d), .igual(eq_d), .maior(gt_d), .menor(lt_d));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard for u_b: expected result and latency per accepted start
  typedef struct {
    logic [2:0] res;
    int         lat;
    int         start_cyc;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (!rst && done_b) begin
      if (sb.size() == 0) begin
        chk("b_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("b_result", int'({eq_b, gt_b, lt_b}), int'(e.res));
        chk("b_latency", cyc - e.start_cyc, e.lat);
        chk("b_busy_at_done", int'(busy_b), 0);
      end
    end
  end

  // Reference: first differing 4-bit digit from the MSB decides
  task automatic model_b(input logic [15:0] x, input logic [15:0] y,
                         output logic [2:0] res, output int lat);
    res = EQ;
    lat = 4;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] da, db;
      da = x[15 - 4*k -: 4];
      db = y[15 - 4*k -: 4];
      if (da != db) begin
        res = (da > db) ? GT : LT;
        lat = k + 1;
        break;
      end
    end
  endtask

  // Called at a negedge where u_b is idle or in its done cycle; returns at done
  task automatic issue_b(input logic [15:0] x, input logic [15:0] y,
                         input logic [2:0] res, input int lat);
    exp_t e;
    int   n;
    start_b = 1'b1;
    x_b = x;
    y_b = y;
    e.res = res;
    e.lat = lat;
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start_b = 1'b0;
    x_b = ~x;
    y_b = ~y;
    chk("b_busy_after_start", int'(busy_b), 1);
    n = 0;
    while (!done_b && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done_b) chk("b_timeout", 0, 1);
  endtask

  // u_c single run; returns result and cycle count from accept edge to done
  task automatic run_c(input logic [7:0] x, input logic [7:0] y, input logic s,
                       output logic [2:0] res, output int lat);
    start_c = 1'b1;
    x_c = x;
    y_c = y;
    sgn_c = s;
    @(negedge clk);
    start_c = 1'b0;
    lat = 0;
    while (!done_c && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (!done_c) chk("c_timeout", 0, 1);
    res = {eq_c, gt_c, lt_c};
    @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [2:0]  res;
    int          lat;
  } vec_t;

  initial begin
    vec_t       tbl[8];
    logic [2:0] r;
    int         l;
    int         n;
    logic [15:0] rx, ry;

    tbl[0] = '{16'hBEEF, 16'hBEEF, EQ, 4};
    tbl[1] = '{16'h0001, 16'h0002, LT, 4};
    tbl[2] = '{16'h1234, 16'h1235, LT, 4};
    tbl[3] = '{16'hF000, 16'h0FFF, GT, 1};
    tbl[4] = '{16'h0120, 16'h0110, GT, 3};
    tbl[5] = '{16'h0000, 16'hFFFF, LT, 1};
    tbl[6] = '{16'hABCD, 16'hAB0D, GT, 3};
    tbl[7] = '{16'h5555, 16'h5565, LT, 3};

    // Reset: hold two cycles, everything must be zero
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a", int'({busy_a, done_a, eq_a, gt_a, lt_a}), 0);
    chk("rst_b", int'({busy_b, done_b, eq_b, gt_b, lt_b}), 0);
    chk("rst_c", int'({busy_c, done_c, eq_c, gt_c, lt_c}), 0);
    chk("rst_d", int'({busy_d, done_d, eq_d, gt_d, lt_d}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Early exit on u_a: 1010 vs 1001 decides at digit 2 (edge 3)
    start_a = 1'b1;
    x_a = 4'b1010;
    y_a = 4'b1001;
    @(negedge clk);
    start_a = 1'b0;
    chk("a_busy_after_start", int'(busy_a), 1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("a_done_edge%0d", i), int'(done_a), (i == 3) ? 1 : 0);
      chk($sformatf("a_busy_edge%0d", i), int'(busy_a), (i < 3) ? 1 : 0);
    end
    chk("a_result", int'({eq_a, gt_a, lt_a}), int'(GT));
    @(negedge clk);
    chk("a_done_pulse_width", int'(done_a), 0);
    chk("a_result_hold", int'({eq_a, gt_a, lt_a}), int'(GT));

    // Table on u_b, back-to-back: each start lands in the previous done cycle
    foreach (tbl[i]) issue_b(tbl[i].x, tbl[i].y, tbl[i].res, tbl[i].lat);
    // Random vectors, often sharing upper digits to spread the latency
    for (int i = 0; i < 16; i++) begin
      rx = 16'($urandom);
      ry = (i % 3 == 0) ? 16'($urandom) : (rx ^ 16'(16'h1 << $urandom_range(0, 15)));
      if (i % 5 == 4) ry = rx;
      model_b(rx, ry, r, l);
      issue_b(rx, ry, r, l);
    end
    @(negedge clk);
    @(negedge clk);
    chk("b_scoreboard_drained", sb.size(), 0);

    // Constant time on u_c: decided at digit 0 but done only after 8 cycles
    start_c = 1'b1;
    x_c = 8'h80;
    y_c = 8'h7F;
    @(negedge clk);
    start_c = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("c_done_edge%0d", i), int'(done_c), (i == 8) ? 1 : 0);
      if (i < 8) chk($sformatf("c_busy_edge%0d", i), int'(busy_c), 1);
      if (i < 8) chk($sformatf("c_no_early_result%0d", i), int'({eq_c, gt_c, lt_c}), 0);
      // Stray start pulses with different operands while busy
      start_c = (i == 2 || i == 5) ? 1'b1 : 1'b0;
      x_c = 8'h00;
      y_c = 8'hFF;
    end
    chk("c_result", int'({eq_c, gt_c, lt_c}), int'(GT));
    start_c = 1'b0;
    @(negedge clk);
    chk("c_ignored_start", int'(busy_c), 0);
    run_c(8'h3C, 8'h3C, 1'b0, r, l);
    chk("c_equal_result", int'(r), int'(EQ));
    chk("c_equal_latency", l, 8);
    run_c(8'h01, 8'h41, 1'b0, r, l);
    chk("c_late_less", int'(r), int'(LT));
    chk("c_late_less_latency", l, 8);

`ifdef COMP_SIGNED_EN
    run_c(8'hFF, 8'h01, 1'b1, r, l);
    chk("c_signed_neg_lt_pos", int'(r), int'(LT));
    run_c(8'hFF, 8'h01, 1'b0, r, l);
    chk("c_unsigned_ff_gt_01", int'(r), int'(GT));
    run_c(8'h80, 8'hFE, 1'b1, r, l);
    chk("c_signed_min_lt_m2", int'(r), int'(LT));
    sgn_c = 1'b0;
`endif

    // u_d: a full 16-digit compare first, then reset in the middle of one
    start_d = 1'b1;
    x_d = 16'h0001;
    y_d = 16'h0000;
    @(negedge clk);
    start_d = 1'b0;
    n = 0;
    while (!done_d && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("d_first_latency", n, 16);
    chk("d_first_result", int'({eq_d, gt_d, lt_d}), int'(GT));
    @(negedge clk);
    start_d = 1'b1;
    x_d = 16'hAAAA;
    y_d = 16'hAAAA;
    @(negedge clk);
    start_d = 1'b0;
    @(negedge clk);
    chk("d_busy_run2", int'(busy_d), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("d_after_rst", int'({busy_d, done_d, eq_d, gt_d, lt_d}), 0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_d || busy_d) n++;
    end
    chk("d_no_done_after_abort", n, 0);
    start_d = 1'b1;
    x_d = 16'h0003;
    y_d = 16'h0005;
    @(negedge clk);
    start_d = 1'b0;
    n = 0;
    while (!done_d && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("d_restart_latency", n, 14);
    chk("d_restart_result", int'({eq_d, gt_d, lt_d}), int'(LT));

    // rst has priority over start
    @(negedge clk);
    start_d = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("d_rst_over_start", int'({busy_d, done_d, eq_d, gt_d, lt_d}), 0);
    start_d = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
